serial_fas: RTL and testbench

Bit-serial N-bit adder/subtractor built around a single `fas` full adder/subtractor cell. It sits directly upstream of `fas`. It latches two N-bit operands and a mode bit, then presents one operand bit pair per clock, LSB first, to the `fas` cell. The carry/borrow is registered between bit steps, and the serial sum/difference bits are collected into an N-bit result with carry/borrow and signed-overflow flags.

---
 rtl/serial_fas.sv | 128 ++++++++++++
 tb/tb_serial_fas.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_fas.sv
// serial_fas -- bit-serial N-bit adder/subtractor around a single fas cell.
//
// Ports:
//   clk, rst         single clock (rising edge), asynchronous active-high reset
//   start            request; accepted only when not busy (IDLE or DONE)
//   a, b, a_ns       operands and mode (0 = A+B, 1 = A-B), latched on accept
//   busy             high while operand bits are being processed (RUN)
//   done             one-cycle pulse in the cycle after result/cout/ovf update
//   result           sum/difference mod 2^N, held until the next completion
//   cout             add: carry out of bit N-1; subtract: borrow (A < B)
//   ovf              two's-complement signed overflow

// One-bit full adder / full subtractor. In subtract mode cout is the borrow.
module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);
    assign s = a ^ b ^ cin;

    always_comb begin
        cout = (a & b) | ((a ^ b) & cin);
        if (a_ns)
            cout = (~a & b) | (~(a ^ b) & cin);
    end
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit pair per clock, LSB first
// DONE  | outputs just updated; done pulse; start accepted here too
module serial_fas #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         a_ns,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  sa, sb, sr;
    logic          m, c;
    logic [CW-1:0] cnt;
    logic          fas_s, fas_cout;
    logic          accept, last_bit;

    fas u_fas (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (c),
        .a_ns (m),
        .s    (fas_s),
        .cout (fas_cout)
    );

    assign accept   = start && (state != RUN);
    assign last_bit = (cnt == CW'(N - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            m      <= 1'b0;
            c      <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            m   <= a_ns;
            c   <= 1'b0;
            cnt <= '0;
            sr  <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= {fas_s, sr[N-1:1]};
            c   <= fas_cout;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
                // On the last step sa[0]/sb[0] are the operand MSBs and
                // fas_s is the result MSB.
                result <= {fas_s, sr[N-1:1]};
                cout   <= fas_cout;
                if (m)
                    ovf <= (sa[0] != sb[0]) && (fas_s != sa[0]);
                else
                    ovf <= (sa[0] == sb[0]) && (fas_s != sa[0]);
            end
        end
    end
endmodule

// File: tb/tb_serial_fas.sv
module tb_serial_fas;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         a_ns = 1'b0;
    logic         busy, done, cout, ovf;
    logic [N-1:0] result;

    serial_fas #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .a_ns   (a_ns),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           done_cnt = 0;
    logic [N-1:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse is matched to the oldest request.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e.r);
                check("cout", cout, e.c);
                check("ovf", ovf, e.o);
                last_res = e.r;
            end
        end
    end

    function automatic exp_t model(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic m);
        exp_t   e;
        logic [N:0] full;
        int     sv;
        full = m ? ({1'b0, ta} - {1'b0, tb}) : ({1'b0, ta} + {1'b0, tb});
        sv   = m ? (int'($signed(ta)) - int'($signed(tb))) : (int'($signed(ta)) + int'($signed(tb)));
        e.r  = full[N-1:0];
        e.c  = full[N];
        e.o  = (sv > 127) || (sv < -128);
        return e;
    endfunction

    // Drives one operation from a point away from the rising edge and
    // returns at the falling edge of the DONE cycle.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic m,
                          input bit disturb, input bit keep_start);
        int k = 0;
        int busy_cnt = 0;
        bit got_done = 0;
        sb_q.push_back(model(ta, tb, m));
        a     = ta;
        b     = tb;
        a_ns  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        while (k < 20 && !got_done) begin
            @(negedge clk);
            k++;
            if (disturb && k == 2) begin
                start = 1'b1;
                a     = ~ta;
                b     = $urandom_range(0, 255);
                a_ns  = ~m;
            end
            if (disturb && k == 4) start = 1'b0;
            if (busy) begin
                busy_cnt++;
                check("result_hold", result, last_res);
            end
            if (done) got_done = 1;
        end
        check("done_latency", k, N + 1);
        check("busy_cycles", busy_cnt, N);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h3C, 8'h0F, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0);
        @(negedge clk);
        run_op(8'h7F, 8'h01, 1'b0, 0, 0);
        @(negedge clk);
        run_op(8'h05, 8'h07, 1'b1, 0, 0);
        run_op(8'h80, 8'h01, 1'b1, 0, 0);
        repeat (3) @(negedge clk);
        run_op(8'h5A, 8'h5A, 1'b1, 0, 0);
        @(negedge clk);

        // start pulsed and operands changed mid-operation
        run_op(8'h12, 8'h34, 1'b0, 1, 0);
        @(negedge clk);
        run_op(8'hA0, 8'h31, 1'b1, 1, 0);
        @(negedge clk);

        // start held continuously: completion every N+1 cycles
        run_op(8'h11, 8'h22, 1'b0, 0, 1);
        run_op(8'h90, 8'h90, 1'b0, 0, 1);
        run_op(8'h01, 8'h02, 1'b1, 0, 0);
        @(negedge clk);

        // asynchronous reset mid-cycle while idle
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_result", result, 0);
        check("arst_cout", cout, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        @(negedge clk);
        run_op(8'hC3, 8'h3D, 1'b0, 0, 0);
        @(negedge clk);

        // reset mid-operation at bit 4
        begin
            int d0;
            a = 8'h44; b = 8'h55; a_ns = 1'b0; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (4) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("abort_busy", busy, 0);
            check("abort_result", result, 0);
            d0 = done_cnt;
            @(negedge clk);
            rst = 1'b0;
            last_res = '0;
            repeat (15) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_result_after", result, 0);
        end
        run_op(8'h66, 8'h19, 1'b1, 0, 0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, 0);
            if (i % 2 == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
